// File: rtl/i4004_bus_ctrl.sv
// MCS-4 CPU-side bus controller: sequences the A1..X3 instruction cycle, drives
// address/SRC/I-O data onto the 4-bit bus and captures fetched opcodes and I/O reads.
module i4004_bus_ctrl #(
  parameter int CM_RAM_LINES = 4
) (
  input  logic                    cp2,
  input  logic                    reset,
  inout  wire  [3:0]              data,
  output logic                    sync,
  output logic                    cm_rom,
  output logic [CM_RAM_LINES-1:0] cm_ram,
  input  logic [11:0]             pc,
  input  logic [7:0]              src_data,
  input  logic [3:0]              acc,
  input  logic                    dcl_we,
  input  logic [1:0]              dcl_val,
  output logic [7:0]              instr,
  output logic                    instr_valid,
  output logic [3:0]              io_rdata,
  output logic                    io_rdata_valid
);

  typedef enum logic [7:0] {
    ST_A1 = 8'b0000_0001,
    ST_A2 = 8'b0000_0010,
    ST_A3 = 8'b0000_0100,
    ST_M1 = 8'b0000_1000,
    ST_M2 = 8'b0001_0000,
    ST_X1 = 8'b0010_0000,
    ST_X2 = 8'b0100_0000,
    ST_X3 = 8'b1000_0000
  } state_e;

  state_e                  state_q, state_d;
  logic [11:0]             pc_q;
  logic [3:0]              opr_q;
  logic [7:0]              instr_q;
  logic                    instr_valid_q;
  logic [7:0]              src_q;
  logic [3:0]              acc_q;
  logic [3:0]              io_rdata_q;
  logic                    io_rdata_valid_q;
  logic [1:0]              bank_q;
  logic [1:0]              bank_sh_q;

  logic                    drive_en_q, drive_en_d;
  logic [3:0]              bus_q, bus_d;
  logic                    cm_rom_q, cm_rom_d;
  logic [CM_RAM_LINES-1:0] cm_ram_q, cm_ram_d;
  logic                    sync_q, sync_d;

  logic                    src_s;
  logic                    io_s;
  logic                    io_wr_s;
  logic                    io_rd_s;

  // Banks beyond the implemented lines decode to all zeros.
  function automatic logic [CM_RAM_LINES-1:0] bank_onehot(input logic [1:0] b);
    logic [CM_RAM_LINES-1:0] v;
    v = '0;
    for (int i = 0; i < CM_RAM_LINES; i++) begin
      v[i] = (i < 4) && (b == 2'(i));
    end
    return v;
  endfunction

  assign src_s   = (instr_q[7:4] == 4'b0010) && instr_q[0];
  assign io_s    = (instr_q[7:4] == 4'b1110);
  assign io_wr_s = io_s && !instr_q[3];
  assign io_rd_s = io_s && instr_q[3];

  // Ring successor of the current state.
  always_comb begin
    state_d = ST_A1;
    case (state_q)
      ST_A1:   state_d = ST_A2;
      ST_A2:   state_d = ST_A3;
      ST_A3:   state_d = ST_M1;
      ST_M1:   state_d = ST_M2;
      ST_M2:   state_d = ST_X1;
      ST_X1:   state_d = ST_X2;
      ST_X2:   state_d = ST_X3;
      ST_X3:   state_d = ST_A1;
      default: state_d = ST_A1;
    endcase
  end

  // Rising-edge state, bus sampling and operand capture.
  always_ff @(posedge cp2 or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_X3;
      pc_q             <= 12'h000;
      opr_q            <= 4'h0;
      instr_q          <= 8'h00;
      instr_valid_q    <= 1'b0;
      src_q            <= 8'h00;
      acc_q            <= 4'h0;
      io_rdata_q       <= 4'h0;
      io_rdata_valid_q <= 1'b0;
      bank_q           <= 2'b00;
      bank_sh_q        <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == ST_X3) pc_q <= pc;
      if (state_q == ST_M1) opr_q <= data;
      // The bank shadow is taken from the pre-edge bank so a DCL landing on this edge waits a cycle.
      if (state_q == ST_M2) begin
        instr_q   <= {opr_q, data};
        bank_sh_q <= bank_q;
      end
      instr_valid_q <= (state_q == ST_M2);
      if (state_q == ST_X1) begin
        src_q <= src_data;
        acc_q <= acc;
      end
      if ((state_q == ST_X2) && io_rd_s) io_rdata_q <= data;
      io_rdata_valid_q <= (state_q == ST_X2) && io_rd_s;
      if (dcl_we) bank_q <= dcl_val;
    end
  end

  // Bus ownership and control-line values for the current state.
  always_comb begin
    drive_en_d = 1'b0;
    bus_d      = 4'h0;
    cm_rom_d   = 1'b0;
    cm_ram_d   = '0;
    sync_d     = 1'b0;
    case (state_q)
      ST_A1: begin
        drive_en_d = 1'b1;
        bus_d      = pc_q[3:0];
      end
      ST_A2: begin
        drive_en_d = 1'b1;
        bus_d      = pc_q[7:4];
      end
      ST_A3: begin
        drive_en_d = 1'b1;
        bus_d      = pc_q[11:8];
        cm_rom_d   = 1'b1;
      end
      ST_M1: begin
        drive_en_d = 1'b0;
      end
      ST_M2: begin
        if (opr_q == 4'b1110) begin
          cm_rom_d = 1'b1;
          cm_ram_d = bank_onehot(bank_q);
        end else begin
          cm_rom_d = 1'b0;
        end
      end
      ST_X1: begin
        drive_en_d = 1'b0;
      end
      ST_X2: begin
        if (src_s || io_s) begin
          cm_rom_d   = 1'b1;
          cm_ram_d   = bank_onehot(bank_sh_q);
          drive_en_d = src_s || io_wr_s;
          bus_d      = src_s ? src_q[3:0] : acc_q;
        end else begin
          drive_en_d = 1'b0;
        end
      end
      ST_X3: begin
        sync_d = 1'b1;
        if (src_s) begin
          drive_en_d = 1'b1;
          bus_d      = src_q[7:4];
        end else begin
          drive_en_d = 1'b0;
        end
      end
      default: begin
        drive_en_d = 1'b0;
      end
    endcase
  end

  // Falling-edge bus drivers: values settle mid-state and hold through the state's end edge.
  always_ff @(negedge cp2 or negedge reset) begin
    if (!reset) begin
      drive_en_q <= 1'b0;
      bus_q      <= 4'h0;
      cm_rom_q   <= 1'b0;
      cm_ram_q   <= '0;
      sync_q     <= 1'b1;
    end else begin
      drive_en_q <= drive_en_d;
      bus_q      <= bus_d;
      cm_rom_q   <= cm_rom_d;
      cm_ram_q   <= cm_ram_d;
      sync_q     <= sync_d;
    end
  end

  assign data           = drive_en_q ? bus_q : 4'bzzzz;
  assign sync           = sync_q;
  assign cm_rom         = cm_rom_q;
  assign cm_ram         = cm_ram_q;
  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;
  assign io_rdata       = io_rdata_q;
  assign io_rdata_valid = io_rdata_valid_q;

endmodule

// File: tb/tb_i4004_bus_ctrl.sv
// Bench for i4004_bus_ctrl: directed test-plan steps then random instruction cycles,
// each checked state by state against a per-cycle table built from the bus rules.
module tb_i4004_bus_ctrl;

  logic        cp2 = 1'b0;
  logic        reset;
  wire  [3:0]  data;
  logic        sync;
  logic        cm_rom;
  logic [3:0]  cm_ram;
  logic [11:0] pc;
  logic [7:0]  src_data;
  logic [3:0]  acc;
  logic        dcl_we;
  logic [1:0]  dcl_val;
  logic [7:0]  instr;
  logic        instr_valid;
  logic [3:0]  io_rdata;
  logic        io_rdata_valid;

  logic        slv_en;
  logic [3:0]  slv_val;
  int          total = 0;
  int          bad = 0;
  int          bank_m = 0;

  assign data = slv_en ? slv_val : 4'bzzzz;

  i4004_bus_ctrl #(.CM_RAM_LINES(4)) dut (
    .cp2(cp2), .reset(reset), .data(data), .sync(sync), .cm_rom(cm_rom),
    .cm_ram(cm_ram), .pc(pc), .src_data(src_data), .acc(acc), .dcl_we(dcl_we),
    .dcl_val(dcl_val), .instr(instr), .instr_valid(instr_valid),
    .io_rdata(io_rdata), .io_rdata_valid(io_rdata_valid)
  );

  always #5 cp2 = ~cp2;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check(tag, {data, cm_rom, cm_ram, sync, instr_valid, io_rdata_valid, 4'h0},
          {4'bzzzz, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'h0});
    check({tag, "_regs"}, {4'h0, instr, io_rdata}, 16'h0000);
  endtask

  function automatic logic [3:0] oh(input int b);
    return 4'b0001 << b;
  endfunction

  // One full A1..X3 cycle: slave supplies ins in M1/M2 (and rd in a read X2).
  task automatic do_cycle(input logic [7:0] ins, input logic [3:0] rd, input bit dcl,
                          input logic [1:0] dv, input int abort_at);
    logic [3:0] opr, opa;
    logic [3:0] eb [8];
    logic       er [8];
    logic [3:0] em [8];
    logic [15:0] ev;
    bit is_src, is_io, is_wr, is_rd;
    opr = ins[7:4];
    opa = ins[3:0];
    is_src = (opr == 4'b0010) && opa[0];
    is_io  = (opr == 4'b1110);
    is_wr  = is_io && !opa[3];
    is_rd  = is_io && opa[3];
    for (int k = 0; k < 8; k++) begin
      eb[k] = 4'bzzzz;
      er[k] = 1'b0;
      em[k] = 4'b0000;
    end
    eb[0] = pc[3:0];
    eb[1] = pc[7:4];
    eb[2] = pc[11:8];
    eb[3] = opr;
    eb[4] = opa;
    eb[6] = is_src ? src_data[3:0] : (is_wr ? acc : (is_rd ? rd : 4'bzzzz));
    eb[7] = is_src ? src_data[7:4] : 4'bzzzz;
    er[2] = 1'b1;
    er[4] = is_io;
    er[6] = is_src || is_io;
    em[4] = is_io ? oh(bank_m) : 4'b0000;
    em[6] = (is_src || is_io) ? oh(bank_m) : 4'b0000;
    for (int s = 0; s < 8; s++) begin
      @(posedge cp2);
      @(negedge cp2);
      case (s)
        3: begin slv_en = 1'b1; slv_val = opr; end
        4: slv_val = opa;
        5: slv_en = 1'b0;
        6: begin
          if (is_rd) begin slv_en = 1'b1; slv_val = rd; end
          if (dcl) begin dcl_we = 1'b1; dcl_val = dv; end
        end
        7: begin slv_en = 1'b0; dcl_we = 1'b0; end
        default: ;
      endcase
      #2;
      if (s == abort_at) begin
        slv_en = 1'b0;
        reset = 1'b0;
        #1;
        check_reset("abort_now");
        @(posedge cp2);
        #2;
        check_reset("abort_held");
        @(negedge cp2);
        reset = 1'b1;
        bank_m = 0;
        return;
      end
      ev = {eb[s], er[s], em[s], (s == 7), (s == 5), (s == 7) && is_rd, 4'h0};
      check($sformatf("ins%02h_st%0d", ins, s),
            {data, cm_rom, cm_ram, sync, instr_valid, io_rdata_valid, 4'h0}, ev);
      if (s == 5) check($sformatf("instr_%02h", ins), {8'h00, instr}, {8'h00, ins});
      if ((s == 7) && is_rd) check($sformatf("io_rdata_%02h", ins), {12'h000, io_rdata}, {12'h000, rd});
    end
    if (dcl) bank_m = int'(dv);
  endtask

  initial begin
    logic [7:0] ins;
    reset    = 1'b1;
    slv_en   = 1'b0;
    slv_val  = 4'h0;
    dcl_we   = 1'b0;
    dcl_val  = 2'b00;
    pc       = 12'hABC;
    src_data = 8'h00;
    acc      = 4'h0;
    #1 reset = 1'b0;
    #1 check_reset("reset_init");
    @(negedge cp2);
    @(negedge cp2);
    reset = 1'b1;

    do_cycle(8'h00, 4'h0, 1'b0, 2'b00, 8);
    do_cycle(8'h00, 4'h0, 1'b1, 2'b01, 8);
    src_data = 8'h3E;
    do_cycle(8'h25, 4'h0, 1'b0, 2'b00, 8);
    acc = 4'h7;
    do_cycle(8'hE0, 4'h0, 1'b0, 2'b00, 8);
    do_cycle(8'hE9, 4'h7, 1'b0, 2'b00, 8);
    do_cycle(8'hE9, 4'h9, 1'b0, 2'b00, 8);

    do_cycle(8'h25, 4'h0, 1'b0, 2'b00, 3);
    pc = 12'h123;
    do_cycle(8'h00, 4'h0, 1'b0, 2'b00, 8);

    src_data = 8'h5A;
    do_cycle(8'h21, 4'h0, 1'b1, 2'b11, 8);
    do_cycle(8'h23, 4'h0, 1'b0, 2'b00, 8);

    for (int i = 0; i < 40; i++) begin
      pc       = 12'($urandom);
      src_data = 8'($urandom);
      acc      = 4'($urandom);
      case ($urandom_range(0, 3))
        0:       ins = {4'b0010, 3'($urandom), 1'b1};
        1:       ins = {5'b11100, 3'($urandom)};
        2:       ins = {5'b11101, 3'($urandom)};
        default: ins = 8'($urandom);
      endcase
      do_cycle(ins, 4'($urandom), ($urandom_range(0, 2) == 0), 2'($urandom), 8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
